// File: rtl/wb_pwm.sv
// wb_pwm: multi-channel PWM generator with a Wishbone slave port.
// Optional PWM_SHADOW_EN: buffered duty registers, applied at period wrap.
module wb_pwm #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    output logic                wb_ack_o,
    output logic                intr,
    output logic [CHANNELS-1:0] pwm_o
);

    localparam int W = CNT_WIDTH;

    logic         bus_req;
    logic         wr;
    logic [2:0]   off;
    logic         en;
    logic         ie;
    logic         done;
    logic [W-1:0] prescale;
    logic [W-1:0] period;
    logic [W-1:0] pcnt;
    logic [W-1:0] cnt;
    logic [W-1:0] duty     [CHANNELS];
    logic [W-1:0] duty_act [CHANNELS];
    logic         tick;
    logic         wrap;
    logic [31:0]  rdata;
    logic         unused_adr;

    assign bus_req    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr         = bus_req & wb_we_i;
    assign off        = wb_adr_i[4:2];
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    assign tick = en && (pcnt >= prescale);
    assign wrap = tick && (cnt >= period);
    assign intr = done & ie;

    function automatic logic [W-1:0] lane_wr(
        input logic [W-1:0] old,
        input logic [31:0]  d,
        input logic [3:0]   sel
    );
        logic [31:0] o;
        o = 32'(old);
        for (int b = 0; b < 4; b++)
            if (sel[b]) o[b*8 +: 8] = d[b*8 +: 8];
        return o[W-1:0];
    endfunction

    // Single-wait-state ack; read data only on read acks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_req;
            wb_dat_o <= (bus_req && !wb_we_i) ? rdata : '0;
        end
    end

    // Control, prescale and period registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            prescale <= '0;
            period   <= '0;
        end else if (wr) begin
            case (off)
                3'd0: if (wb_sel_i[0]) begin
                    en <= wb_dat_i[0];
                    ie <= wb_dat_i[1];
                end
                3'd1: prescale <= lane_wr(prescale, wb_dat_i, wb_sel_i);
                3'd2: period   <= lane_wr(period, wb_dat_i, wb_sel_i);
                default: ;
            endcase
        end
    end

    // DONE flag: wrap sets, W1C clears, set wins on collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            done <= 1'b0;
        else if (wrap)
            done <= 1'b1;
        else if (wr && off == 3'd3 && wb_sel_i[0] && wb_dat_i[0])
            done <= 1'b0;
    end

    // Duty registers (shadow copies when buffering is enabled)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < CHANNELS; n++) duty[n] <= '0;
        end else if (wr && off[2]) begin
            for (int n = 0; n < CHANNELS; n++)
                if (off[1:0] == 2'(n))
                    duty[n] <= lane_wr(duty[n], wb_dat_i, wb_sel_i);
        end
    end

`ifdef PWM_SHADOW_EN
    // Active duty follows the shadow only at wrap or while stopped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < CHANNELS; n++) duty_act[n] <= '0;
        end else if (!en || wrap) begin
            for (int n = 0; n < CHANNELS; n++) duty_act[n] <= duty[n];
        end
    end
`else
    // Active duty is the written register itself
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) duty_act[n] = duty[n];
    end
`endif

    // Prescaler and period counter; both held at 0 while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (!en) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            cnt  <= wrap ? '0 : cnt + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Registered compare outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_o <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++)
                pwm_o[n] <= en && (cnt < duty_act[n]);
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        case (off)
            3'd0: rdata = {30'd0, ie, en};
            3'd1: rdata = 32'(prescale);
            3'd2: rdata = 32'(period);
            3'd3: rdata = {31'd0, done};
            default: begin
                for (int n = 0; n < CHANNELS; n++)
                    if (off[1:0] == 2'(n)) rdata = 32'(duty[n]);
            end
        endcase
    end

endmodule

// File: tb/tb_wb_pwm.sv
// tb_wb_pwm: directed bench for wb_pwm (register table plus
// hand-timed waveform, interrupt, shrink, shadow and reset sequences).
module tb_wb_pwm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        ack;
    logic        intr;
    logic [3:0]  pwm;

    int passed = 0;
    int total  = 0;

    logic [31:0] wv [4];
    logic [31:0] rd;
    logic [31:0] expv;

    typedef struct {
        logic        we;
        logic [2:0]  off;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    wb_pwm #(.CHANNELS(4), .CNT_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_ack_o (ack),
        .intr     (intr),
        .pwm_o    (pwm)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wb_write(input logic [2:0] o, input logic [31:0] d,
                            input logic [3:0] s);
        @(posedge clk); #1;
        adr = {27'd0, o, 2'b00}; dat_i = d; sel = s;
        we = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        check("write ack", {31'd0, ack}, 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] o, output logic [31:0] d);
        @(posedge clk); #1;
        adr = {27'd0, o, 2'b00}; sel = 4'hF;
        we = 1'b0; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        check("read ack", {31'd0, ack}, 32'd1);
        d = dat_o;
        stb = 1'b0; cyc = 1'b0;
    endtask

    // Sample all pwm outputs for n cycles, bit k-1 = cycle k
    task automatic sample(input int n);
        for (int c = 0; c < 4; c++) wv[c] = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            for (int c = 0; c < 4; c++) wv[c][k] = pwm[c];
        end
    endtask

    initial begin
        // Reset
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset pwm", {28'd0, pwm}, 32'd0);
        check("reset intr", {31'd0, intr}, 32'd0);
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset dat_o", dat_o, 32'd0);
        rst = 1'b1;

        // Register table
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b0, 3'(i), 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd0, 32'h2, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 3'd0, 32'h0, 4'hF, 32'h2});
        tbl.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_FFFF});
        tbl.push_back('{1'b1, 3'd2, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd2, 32'h1234, 4'b0001, 32'h0});
        tbl.push_back('{1'b0, 3'd2, 32'h0, 4'hF, 32'h34});
        tbl.push_back('{1'b1, 3'd2, 32'hABCD, 4'b0010, 32'h0});
        tbl.push_back('{1'b0, 3'd2, 32'h0, 4'hF, 32'hAB34});
        tbl.push_back('{1'b1, 3'd7, 32'h1234_5555, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 3'd7, 32'h0, 4'hF, 32'h5555});
        tbl.push_back('{1'b1, 3'd3, 32'h1, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 3'd3, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd0, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd1, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd2, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd7, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 3'd0, 32'h0, 4'hF, 32'h0});
        foreach (tbl[i]) begin
            if (tbl[i].we) begin
                wb_write(tbl[i].off, tbl[i].wdat, tbl[i].sel);
            end else begin
                wb_read(tbl[i].off, rd);
                check($sformatf("reg vec %0d", i), rd, tbl[i].exp);
            end
        end
        check("idle intr", {31'd0, intr}, 32'd0);
        check("idle pwm", {28'd0, pwm}, 32'd0);

        // Basic waveform: 3 high / 7 low every 10 clocks
        wb_write(3'd1, 32'd0, 4'hF);
        wb_write(3'd2, 32'd9, 4'hF);
        wb_write(3'd4, 32'd3, 4'hF);
        wb_write(3'd0, 32'd1, 4'hF);
        sample(30);
        expv = '0;
        for (int k = 1; k <= 30; k++) expv[k-1] = ((k - 1) % 10) < 3;
        check("basic pwm0", wv[0], expv);

        // Disable: pwm drops next cycle
        wb_write(3'd0, 32'd0, 4'hF);
        @(posedge clk); #1;
        check("disable pwm", {28'd0, pwm}, 32'd0);

        // Prescale and duty boundaries
        wb_write(3'd1, 32'd1, 4'hF);
        wb_write(3'd2, 32'd4, 4'hF);
        wb_write(3'd5, 32'd0, 4'hF);
        wb_write(3'd6, 32'd5, 4'hF);
        wb_write(3'd7, 32'd2, 4'hF);
        wb_write(3'd0, 32'd1, 4'hF);
        sample(20);
        expv = '0;
        for (int k = 1; k <= 20; k++) expv[k-1] = ((k - 1) % 10) < 4;
        check("presc pwm1 zero", wv[1], 32'h0);
        check("presc pwm2 full", wv[2], 32'h000F_FFFF);
        check("presc pwm3", wv[3], expv);

        // Interrupt
        wb_write(3'd0, 32'd0, 4'hF);
        wb_write(3'd3, 32'd1, 4'hF);
        wb_write(3'd2, 32'd3, 4'hF);
        wb_write(3'd1, 32'd0, 4'hF);
        check("irq pre", {31'd0, intr}, 32'd0);
        wb_write(3'd0, 32'd3, 4'hF);
        expv = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            expv[k] = intr;
        end
        check("irq first wrap", expv, 32'b1000);
        wb_write(3'd3, 32'd1, 4'hF);
        check("irq w1c", {31'd0, intr}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("irq second wrap", {31'd0, intr}, 32'd1);
        wb_write(3'd3, 32'd1, 4'hF);
        check("irq w1c on wrap", {31'd0, intr}, 32'd1);
        wb_read(3'd3, rd);
        check("status after collide", rd, 32'd1);

        // Period shrink below running count
        wb_write(3'd0, 32'd0, 4'hF);
        wb_write(3'd3, 32'd1, 4'hF);
        wb_write(3'd4, 32'h10, 4'hF);
        wb_write(3'd1, 32'd0, 4'hF);
        wb_write(3'd2, 32'h100, 4'hF);
        wb_write(3'd0, 32'd1, 4'hF);
        wb_read(3'd3, rd);
        check("shrink status pre", rd, 32'd0);
        repeat (28) @(posedge clk);
        #1;
        wb_write(3'd2, 32'd2, 4'hF);
        check("shrink pwm pre", {31'd0, pwm[0]}, 32'd0);
        wb_read(3'd3, rd);
        check("shrink status wrap", rd, 32'd1);
        check("shrink pwm post", {31'd0, pwm[0]}, 32'd1);

        // Mid-period duty change 3 -> 7
        wb_write(3'd0, 32'd0, 4'hF);
        wb_write(3'd2, 32'd9, 4'hF);
        wb_write(3'd4, 32'd3, 4'hF);
        wb_write(3'd0, 32'd3, 4'hF);
        wb_write(3'd4, 32'd7, 4'hF);
        sample(18);
        expv = '0;
        for (int k = 3; k <= 20; k++) begin
`ifdef PWM_SHADOW_EN
            expv[k-3] = (k <= 10) ? (((k - 1) % 10) < 3)
                                  : (((k - 1) % 10) < 7);
`else
            expv[k-3] = ((k - 1) % 10) < 7;
`endif
        end
        check("duty change pwm0", wv[0], expv);
        @(posedge clk); #1;
        check("pre-reset pwm0", {31'd0, pwm[0]}, 32'd1);
        check("pre-reset intr", {31'd0, intr}, 32'd1);

        // Reset mid-period
        rst = 1'b0;
        #1;
        check("mid reset pwm", {28'd0, pwm}, 32'd0);
        check("mid reset intr", {31'd0, intr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        wb_read(3'd0, rd);
        check("post reset ctrl", rd, 32'd0);
        wb_read(3'd2, rd);
        check("post reset period", rd, 32'd0);
        wb_read(3'd4, rd);
        check("post reset duty0", rd, 32'd0);
        check("post reset pwm", {28'd0, pwm}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
